// File: rtl/grf_hazard_ctrl_pkg.sv
`default_nettype none
// grf_hazard_ctrl_pkg -- shared encodings and pipeline stage-entry type for the GRF hazard controller.
// Rev 1.0
package grf_hazard_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_LINK = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LOAD = 2'd2;

   localparam logic [1:0] FWD_D_GRF = 2'd0;
   localparam logic [1:0] FWD_D_E   = 2'd1;
   localparam logic [1:0] FWD_D_M   = 2'd2;

   localparam logic [1:0] FWD_E_PIPE = 2'd0;
   localparam logic [1:0] FWD_E_M    = 2'd1;
   localparam logic [1:0] FWD_E_W    = 2'd2;

   localparam int MD_CNT_W = 4;
   localparam logic [MD_CNT_W-1:0] MULT_CYCLES = 4'd5;
   localparam logic [MD_CNT_W-1:0] DIV_CYCLES  = 4'd10;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       md_start;
      logic       md_div;
   } stage_t;

   // $0 is hard-wired, so a write to it never produces a forwardable value.
   function automatic logic producer_match(input logic valid, input logic [4:0] dst,
                                           input logic [4:0] addr);
      return valid && (dst != 5'd0) && (dst == addr);
   endfunction

endpackage
`default_nettype wire

// File: rtl/grf_hazard_ctrl_md_busy_counter.sv
`default_nettype none
// md_busy_counter -- HI/LO unit countdown, loaded when a mult/div sits in E.
// Rev 1.0
module md_busy_counter
   import grf_hazard_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic                i_div,
   output logic [MD_CNT_W-1:0] o_count
);

   localparam logic [MD_CNT_W-1:0] C_ONE = 1;

   logic [MD_CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_start) begin
         r_count <= i_div ? DIV_CYCLES : MULT_CYCLES;
      end else if (r_count != '0) begin
         r_count <= r_count - C_ONE;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/grf_hazard_ctrl.sv
`default_nettype none
// grf_hazard_ctrl -- Tuse/Tnew stall and forwarding control for the 5-stage GRF pipeline.
// Rev 1.0
module grf_hazard_ctrl
   import grf_hazard_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       d_valid,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic [4:0] d_dst,
   input  logic [1:0] d_tnew,
   input  logic       d_md_start,
   input  logic       d_md_div,
   input  logic       d_md_use,
   output logic       stall,
   output logic [1:0] fwd_d_rs,
   output logic [1:0] fwd_d_rt,
   output logic [1:0] fwd_e_rs,
   output logic [1:0] fwd_e_rt,
   output logic       md_busy
);

   stage_t r_e;
   stage_t r_m;
   stage_t r_w;
   stage_t w_e_next;

   logic [MD_CNT_W-1:0] w_md_count;
   logic w_e_md_start;
   logic w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;
   logic w_m_hit_ers, w_m_hit_ert, w_w_hit_ers, w_w_hit_ert;
   logic w_rs_haz, w_rt_haz;
   logic w_unused_fields;

   assign w_e_md_start = r_e.valid & r_e.md_start;

   md_busy_counter u_md_busy_counter (
      .clk     (clk),
      .reset   (reset),
      .i_start (w_e_md_start),
      .i_div   (r_e.md_div),
      .o_count (w_md_count)
   );

   // A mult/div in E counts as busy before the counter has been loaded.
   assign md_busy = (w_md_count != '0) | w_e_md_start;

   assign w_e_hit_rs  = producer_match(r_e.valid, r_e.dst, d_rs);
   assign w_e_hit_rt  = producer_match(r_e.valid, r_e.dst, d_rt);
   assign w_m_hit_rs  = producer_match(r_m.valid, r_m.dst, d_rs);
   assign w_m_hit_rt  = producer_match(r_m.valid, r_m.dst, d_rt);
   assign w_m_hit_ers = producer_match(r_m.valid, r_m.dst, r_e.rs);
   assign w_m_hit_ert = producer_match(r_m.valid, r_m.dst, r_e.rt);
   assign w_w_hit_ers = producer_match(r_w.valid, r_w.dst, r_e.rs);
   assign w_w_hit_ert = producer_match(r_w.valid, r_w.dst, r_e.rt);

   function automatic logic [1:0] fwd_sel(input logic en,
                                          input logic young_ok, input logic [1:0] young_code,
                                          input logic old_ok,   input logic [1:0] old_code);
      if (!en)           return 2'd0;
      else if (young_ok) return young_code;
      else if (old_ok)   return old_code;
      else               return 2'd0;
   endfunction

   always_comb begin
      w_rs_haz = (d_tuse_rs != TUSE_NONE) &&
                 ((w_e_hit_rs && (d_tuse_rs < r_e.tnew)) ||
                  (w_m_hit_rs && (d_tuse_rs < r_m.tnew)));
      w_rt_haz = (d_tuse_rt != TUSE_NONE) &&
                 ((w_e_hit_rt && (d_tuse_rt < r_e.tnew)) ||
                  (w_m_hit_rt && (d_tuse_rt < r_m.tnew)));
      stall    = d_valid && (w_rs_haz || w_rt_haz || (d_md_use && md_busy));

      fwd_d_rs = fwd_sel(d_valid,
                         w_e_hit_rs && (r_e.tnew == TNEW_LINK), FWD_D_E,
                         w_m_hit_rs && (r_m.tnew == TNEW_LINK), FWD_D_M);
      fwd_d_rt = fwd_sel(d_valid,
                         w_e_hit_rt && (r_e.tnew == TNEW_LINK), FWD_D_E,
                         w_m_hit_rt && (r_m.tnew == TNEW_LINK), FWD_D_M);
      fwd_e_rs = fwd_sel(r_e.valid,
                         w_m_hit_ers && (r_m.tnew == TNEW_LINK), FWD_E_M,
                         w_w_hit_ers, FWD_E_W);
      fwd_e_rt = fwd_sel(r_e.valid,
                         w_m_hit_ert && (r_m.tnew == TNEW_LINK), FWD_E_M,
                         w_w_hit_ert, FWD_E_W);
   end

   always_comb begin
      w_e_next = '0;
      if (d_valid && !stall) begin
         w_e_next.valid    = 1'b1;
         w_e_next.dst      = d_dst;
         w_e_next.tnew     = d_tnew;
         w_e_next.rs       = d_rs;
         w_e_next.rt       = d_rt;
         w_e_next.md_start = d_md_start;
         w_e_next.md_div   = d_md_div;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e <= '0;
         r_m <= '0;
         r_w <= '0;
      end else begin
         r_e      <= w_e_next;
         r_m      <= r_e;
         r_m.tnew <= (r_e.tnew != TNEW_LINK) ? (r_e.tnew - 2'd1) : TNEW_LINK;
         r_w      <= r_m;
         r_w.tnew <= TNEW_LINK;
      end
   end

   // Later stages carry the full entry for debug visibility; these fields drive nothing.
   assign w_unused_fields = ^{r_m.rs, r_m.rt, r_m.md_start, r_m.md_div,
                              r_w.rs, r_w.rt, r_w.tnew, r_w.md_start, r_w.md_div};

endmodule
`default_nettype wire

// File: tb/tb_grf_hazard_ctrl.sv
`default_nettype none
// tb_grf_hazard_ctrl -- directed scenarios plus randomized traffic against an instruction-level model.
// Rev 1.0
module tb_grf_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       d_valid = 1'b0;
   logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
   logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
   logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
   logic       stall, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

   grf_hazard_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .d_valid    (d_valid),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_dst      (d_dst),
      .d_tnew     (d_tnew),
      .d_md_start (d_md_start),
      .d_md_div   (d_md_div),
      .d_md_use   (d_md_use),
      .stall      (stall),
      .fwd_d_rs   (fwd_d_rs),
      .fwd_d_rt   (fwd_d_rt),
      .fwd_e_rs   (fwd_e_rs),
      .fwd_e_rt   (fwd_e_rt),
      .md_busy    (md_busy)
   );

   always #5 clk = ~clk;

   // Model: each slot keeps the instruction as issued; its remaining tnew is derived
   // from how many stages it has travelled past E.
   typedef struct {
      bit v;
      int dst;
      int tnew;
      int rs;
      int rt;
      bit mds;
      bit mdd;
   } ins_t;

   ins_t pipe [3];
   int   cyc = 0;
   int   md_end = -1;
   bit   model_ok = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   s_stall, s_busy, s_fdrs, s_fdrt, s_fers, s_fert;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int rem(int k);
      if (k >= 2) return 0;
      return (pipe[k].tnew - k > 0) ? pipe[k].tnew - k : 0;
   endfunction

   function automatic bit hit(int k, int a);
      return pipe[k].v && (pipe[k].dst != 0) && (pipe[k].dst == a);
   endfunction

   function automatic bit haz(int a, int tu);
      if (tu == 3) return 1'b0;
      return (hit(0, a) && tu < rem(0)) || (hit(1, a) && tu < rem(1));
   endfunction

   function automatic int fd(int a);
      if (!d_valid) return 0;
      if (hit(0, a) && rem(0) == 0) return 1;
      if (hit(1, a) && rem(1) == 0) return 2;
      return 0;
   endfunction

   function automatic int fe(int a);
      if (!pipe[0].v) return 0;
      if (hit(1, a) && rem(1) == 0) return 1;
      if (hit(2, a)) return 2;
      return 0;
   endfunction

   task automatic tick();
      bit   busy, stl;
      ins_t nxt;
      @(negedge clk);
      s_stall = int'(stall);
      s_busy  = int'(md_busy);
      s_fdrs  = int'(fwd_d_rs);
      s_fdrt  = int'(fwd_d_rt);
      s_fers  = int'(fwd_e_rs);
      s_fert  = int'(fwd_e_rt);
      busy = (pipe[0].v && pipe[0].mds) || (cyc <= md_end);
      stl  = d_valid && (haz(int'(d_rs), int'(d_tuse_rs)) || haz(int'(d_rt), int'(d_tuse_rt)) ||
                         (d_md_use && busy));
      if (model_ok) begin
         check_eq("stall",    s_stall, int'(stl));
         check_eq("md_busy",  s_busy,  int'(busy));
         check_eq("fwd_d_rs", s_fdrs,  fd(int'(d_rs)));
         check_eq("fwd_d_rt", s_fdrt,  fd(int'(d_rt)));
         check_eq("fwd_e_rs", s_fers,  fe(pipe[0].rs));
         check_eq("fwd_e_rt", s_fert,  fe(pipe[0].rt));
      end
      nxt.v   = d_valid && !stl;
      nxt.dst = int'(d_dst);
      nxt.tnew = int'(d_tnew);
      nxt.rs  = int'(d_rs);
      nxt.rt  = int'(d_rt);
      nxt.mds = d_md_start;
      nxt.mdd = d_md_div;
      if (pipe[0].v && pipe[0].mds) md_end = cyc + (pipe[0].mdd ? 10 : 5);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
      if (reset) begin
         for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
         md_end = -1;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (reset) model_ok = 1'b1;
   endtask

   task automatic drv(input bit v, input int rs, input int rt, input int tur, input int tut,
                      input int dst, input int tnew,
                      input bit mds = 1'b0, input bit mdd = 1'b0, input bit mdu = 1'b0);
      d_valid    = v;
      d_rs       = 5'(rs);
      d_rt       = 5'(rt);
      d_tuse_rs  = 2'(tur);
      d_tuse_rt  = 2'(tut);
      d_dst      = 5'(dst);
      d_tnew     = 2'(tnew);
      d_md_start = mds;
      d_md_div   = mdd;
      d_md_use   = mdu;
   endtask

   task automatic idle(input int n);
      drv(1'b0, 0, 0, 3, 3, 0, 0);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic md_stall_run(input bit is_div, input int want, input string tag);
      int n;
      idle(3);
      drv(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, is_div, 1'b1);
      tick();
      drv(1'b1, 0, 0, 3, 3, 12, 0, 1'b0, 1'b0, 1'b1);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (s_stall == 0) break;
         n++;
         check_eq({tag, "_busy_hold"}, s_busy, 1);
      end
      check_eq({tag, "_stall_cycles"}, n, want);
      check_eq({tag, "_busy_release"}, s_busy, 0);
      idle(1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};

      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(1);
      check_eq("rst_stall", s_stall, 0);
      check_eq("rst_busy",  s_busy,  0);
      check_eq("rst_fwd",   s_fdrs | s_fdrt | s_fers | s_fert, 0);

      // Load-use: lw $8 then add reading $8 at tuse=1.
      drv(1'b1, 0, 0, 3, 3, 8, 2);
      tick();
      drv(1'b1, 8, 0, 1, 3, 11, 1);
      tick();
      check_eq("lu_stall1", s_stall, 1);
      tick();
      check_eq("lu_stall2", s_stall, 0);
      idle(1);
      check_eq("lu_fwd_e_rs", s_fers, 2);

      // ALU result consumed by a branch at tuse=0.
      idle(3);
      drv(1'b1, 0, 0, 3, 3, 9, 1);
      tick();
      drv(1'b1, 9, 0, 0, 3, 0, 0);
      tick();
      check_eq("alu_stall1", s_stall, 1);
      tick();
      check_eq("alu_stall2", s_stall, 0);
      check_eq("alu_fwd_d_rs", s_fdrs, 2);

      // Two producers of $10 in flight: the one in E is younger and wins.
      idle(3);
      drv(1'b1, 0, 0, 3, 3, 10, 0);
      tick();
      tick();
      drv(1'b1, 10, 0, 0, 3, 13, 1);
      tick();
      check_eq("dbl_stall", s_stall, 0);
      check_eq("dbl_fwd_d_rs", s_fdrs, 1);
      idle(3);
      drv(1'b1, 0, 0, 3, 3, 0, 0);
      tick();
      tick();
      drv(1'b1, 0, 0, 0, 0, 13, 1);
      tick();
      check_eq("zero_stall", s_stall, 0);
      check_eq("zero_fwd", s_fdrs | s_fdrt, 0);

      md_stall_run(1'b1, 11, "div");
      md_stall_run(1'b0, 6, "mult");

      // Reset lands while a div counts down and a load-use is pending.
      idle(3);
      drv(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, 1'b1, 1'b1);
      tick();
      drv(1'b1, 0, 0, 3, 3, 8, 2);
      tick();
      drv(1'b1, 8, 0, 1, 3, 11, 1, 1'b0, 1'b0, 1'b1);
      tick();
      check_eq("mid_stall_pre", s_stall, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle(1);
      check_eq("mid_rst_stall", s_stall, 0);
      check_eq("mid_rst_busy",  s_busy,  0);
      check_eq("mid_rst_fwd",   s_fdrs | s_fdrt | s_fers | s_fert, 0);

      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) < 2);
         drv($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0);
         tick();
      end
      reset = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
